// File: rtl/uart_xfer_pkg.sv
// Shared types and constants for the UART loopback transfer controller.
package uart_xfer_pkg;

  localparam int         NUM_BYTES_DEFAULT = 512;
  localparam logic [7:0] ERR_CNT_MAX       = 8'hFF;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_WAIT,
    RX_WRITE,
    RX_DONE
  } rx_state_type;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_REQ,
    TX_RD,
    TX_LOAD,
    TX_BUSY,
    TX_DONE
  } tx_state_type;

endpackage

// File: rtl/uart_xfer_port_arb.sv
// RAM port A arbiter: the receive writer always wins; the transmit reader
// gets the port only in cycles with no write. With no request the port is
// parked at address 0 with the write enable low.
module uart_xfer_port_arb #(
  parameter int ADDR_W = 9
) (
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              grant_wr,
  output logic              grant_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we
);

  // Fixed-priority grant and port mux.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_wr  = wr_req;
    grant_rd  = rd_req && !wr_req;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (grant_wr) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
      mem_we    = 1'b1;
    end else if (grant_rd) begin
      mem_addr  = rd_addr;
    end
  end

endmodule

// File: rtl/uart_xfer_ctrl.sv
// UART loopback sequencer: receive FSM fills the DP-RAM, transmit FSM drains
// it, both sharing RAM port A through uart_xfer_port_arb.
// Optional feature: define UART_XFER_ERR_COUNT_EN to drop frame-error bytes
// and count them in Error_count; otherwise every byte is stored.
module uart_xfer_ctrl
  import uart_xfer_pkg::*;
#(
  parameter int NUM_BYTES = NUM_BYTES_DEFAULT,
  parameter int ADDR_W    = 9
) (
  input  logic              Clock_50,
  input  logic              Reset,
  input  logic              Rx_start,
  input  logic              Tx_start,
  input  logic              Rx_data_ready,
  input  logic [7:0]        Rx_data,
  input  logic              Rx_frame_error,
  output logic              Rx_unload,
  input  logic              Tx_empty,
  output logic              Tx_load,
  output logic [7:0]        Tx_data,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [7:0]        Mem_wdata,
  output logic              Mem_we,
  input  logic [7:0]        Mem_rdata,
  output logic              Rx_done,
  output logic              Tx_done,
  output logic [ADDR_W:0]   Rx_count,
  output logic [7:0]        Error_count
);

  localparam int             PTR_W    = ADDR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BYTES - 1);
  localparam logic [PTR_W-1:0] END_PTR  = PTR_W'(NUM_BYTES);

`ifdef UART_XFER_ERR_COUNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  rx_state_type     rx_state, rx_state_nxt;
  tx_state_type     tx_state, tx_state_nxt;
  logic [PTR_W-1:0] rx_ptr, tx_ptr;
  logic [7:0]       rx_byte;
  logic             rx_err;
  logic             wr_req, rd_req, grant_wr, grant_rd;
  logic             rx_capture, rx_ptr_inc, tx_capture, tx_issue;

  assign Rx_done  = (rx_state == RX_DONE);
  assign Tx_done  = (tx_state == TX_DONE);
  assign Rx_count = rx_ptr;

  // Requests are masked while Reset is high so an aborted cycle never reaches the RAM.
  // Read eligibility compares against rx_ptr before this cycle's write, so the
  // reader can never target the address being written.
  assign wr_req = (rx_state == RX_WRITE) && !(ERR_EN && rx_err) && !Reset;
  assign rd_req = (tx_state == TX_REQ) && ((tx_ptr < rx_ptr) || Rx_done) && !Reset;

  uart_xfer_port_arb #(.ADDR_W(ADDR_W)) u_port_arb (
    .wr_req    (wr_req),
    .wr_addr   (rx_ptr[ADDR_W-1:0]),
    .wr_data   (rx_byte),
    .rd_req    (rd_req),
    .rd_addr   (tx_ptr[ADDR_W-1:0]),
    .grant_wr  (grant_wr),
    .grant_rd  (grant_rd),
    .mem_addr  (Mem_addr),
    .mem_wdata (Mem_wdata),
    .mem_we    (Mem_we)
  );

  // Receive FSM next state: capture a byte, then write it when granted.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_capture   = 1'b0;
    rx_ptr_inc   = 1'b0;
    case (rx_state)
      RX_IDLE:  if (Rx_start) rx_state_nxt = RX_WAIT;
      RX_WAIT: begin
        if (Rx_data_ready) begin
          rx_capture   = 1'b1;
          rx_state_nxt = RX_WRITE;
        end
      end
      RX_WRITE: begin
        if (ERR_EN && rx_err) begin
          rx_state_nxt = RX_WAIT;
        end else if (grant_wr) begin
          rx_ptr_inc   = 1'b1;
          rx_state_nxt = (rx_ptr == LAST_PTR) ? RX_DONE : RX_WAIT;
        end
      end
      default: rx_state_nxt = rx_state;
    endcase
  end

  // Transmit FSM next state: read, hand the byte over, wait for it to drain.
  // When the transmitter is already empty in TX_RD the load is issued at once
  // so Tx_load lines up with Tx_data two cycles after the read address.
  // The first TX_BUSY cycle is the Tx_load cycle, where Tx_empty is still stale.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_capture   = 1'b0;
    tx_issue     = 1'b0;
    case (tx_state)
      TX_IDLE: if (Tx_start) tx_state_nxt = TX_REQ;
      TX_REQ:  if (grant_rd) tx_state_nxt = TX_RD;
      TX_RD: begin
        tx_capture = 1'b1;
        if (Tx_empty) begin
          tx_issue     = 1'b1;
          tx_state_nxt = TX_BUSY;
        end else begin
          tx_state_nxt = TX_LOAD;
        end
      end
      TX_LOAD: begin
        if (Tx_empty) begin
          tx_issue     = 1'b1;
          tx_state_nxt = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (!Tx_load && Tx_empty)
          tx_state_nxt = (tx_ptr == END_PTR) ? TX_DONE : TX_REQ;
      end
      default: tx_state_nxt = tx_state;
    endcase
  end

  // State, pointers and registered handshake outputs.
  always_ff @(posedge Clock_50) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      rx_state  <= RX_IDLE;
      tx_state  <= TX_IDLE;
      rx_ptr    <= '0;
      tx_ptr    <= '0;
      rx_byte   <= '0;
      rx_err    <= 1'b0;
      Rx_unload <= 1'b0;
      Tx_load   <= 1'b0;
      Tx_data   <= '0;
    end else begin
      rx_state  <= rx_state_nxt;
      tx_state  <= tx_state_nxt;
      Rx_unload <= rx_capture;
      Tx_load   <= tx_issue;
      if (rx_capture) begin
        rx_byte <= Rx_data;
        rx_err  <= Rx_frame_error;
      end
      if (rx_ptr_inc) rx_ptr  <= rx_ptr + PTR_W'(1);
      if (tx_capture) Tx_data <= Mem_rdata;
      if (tx_issue)   tx_ptr  <= tx_ptr + PTR_W'(1);
    end
  end

`ifdef UART_XFER_ERR_COUNT_EN
  // Count dropped frame-error bytes, holding at the ceiling instead of wrapping.
  always_ff @(posedge Clock_50) begin
    if (Reset)
      Error_count <= '0;
    else if (rx_state == RX_WRITE && rx_err && Error_count != ERR_CNT_MAX)
      Error_count <= Error_count + 8'd1;
  end
`else
  assign Error_count = '0;
`endif

endmodule

// File: tb/tb_uart_xfer_ctrl.sv
// Self-checking bench for uart_xfer_ctrl: RAM, receive and transmit models
// around the DUT, with an expected-byte queue filled as bytes are fed and
// compared against the Tx_data stream the DUT produces.
module tb_uart_xfer_ctrl;

  localparam int NUM_BYTES = 512;
  localparam int ADDR_W    = 9;

`ifdef UART_XFER_ERR_COUNT_EN
  localparam bit ERR_EN_TB = 1'b1;
`else
  localparam bit ERR_EN_TB = 1'b0;
`endif

  logic              Clock_50 = 1'b0;
  logic              Reset    = 1'b1;
  logic              Rx_start = 1'b0;
  logic              Tx_start = 1'b0;
  logic              Rx_data_ready = 1'b0;
  logic [7:0]        Rx_data = 8'h00;
  logic              Rx_frame_error = 1'b0;
  logic              Rx_unload;
  logic              Tx_empty;
  logic              Tx_load;
  logic [7:0]        Tx_data;
  logic [ADDR_W-1:0] Mem_addr;
  logic [7:0]        Mem_wdata;
  logic              Mem_we;
  logic [7:0]        Mem_rdata;
  logic              Rx_done;
  logic              Tx_done;
  logic [ADDR_W:0]   Rx_count;
  logic [7:0]        Error_count;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] ram [NUM_BYTES];
  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];
  int         unload_cnt = 0;
  int         load_cnt   = 0;
  int         order_viol = 0;
  int         tx_cnt     = 0;
  logic       tx_hold    = 1'b0;

  uart_xfer_ctrl #(.NUM_BYTES(NUM_BYTES), .ADDR_W(ADDR_W)) dut (
    .Clock_50       (Clock_50),
    .Reset          (Reset),
    .Rx_start       (Rx_start),
    .Tx_start       (Tx_start),
    .Rx_data_ready  (Rx_data_ready),
    .Rx_data        (Rx_data),
    .Rx_frame_error (Rx_frame_error),
    .Rx_unload      (Rx_unload),
    .Tx_empty       (Tx_empty),
    .Tx_load        (Tx_load),
    .Tx_data        (Tx_data),
    .Mem_addr       (Mem_addr),
    .Mem_wdata      (Mem_wdata),
    .Mem_we         (Mem_we),
    .Mem_rdata      (Mem_rdata),
    .Rx_done        (Rx_done),
    .Tx_done        (Tx_done),
    .Rx_count       (Rx_count),
    .Error_count    (Error_count)
  );

  initial forever #10 Clock_50 = ~Clock_50;

  // Dual-port RAM port A model: one-cycle registered read.
  always @(posedge Clock_50) begin
    if (Mem_we === 1'b1) ram[Mem_addr] <= Mem_wdata;
    Mem_rdata <= ram[Mem_addr];
  end

  // Transmit controller model: busy for 10 cycles after each Tx_load.
  always @(negedge Clock_50) begin
    if (Tx_load === 1'b1) tx_cnt = 10;
    else if (tx_cnt > 0) tx_cnt = tx_cnt - 1;
  end
  assign Tx_empty = (tx_cnt == 0) && !tx_hold;

  // Output monitor: records handshakes and the transmitted byte stream.
  always @(negedge Clock_50) begin
    if (Reset === 1'b1) begin
      unload_cnt = 0;
      load_cnt   = 0;
      order_viol = 0;
      obs_q.delete();
    end else begin
      if (Rx_unload === 1'b1) unload_cnt = unload_cnt + 1;
      if (Tx_load === 1'b1) begin
        obs_q.push_back(Tx_data);
        load_cnt = load_cnt + 1;
        if (load_cnt > int'(Rx_count)) order_viol = order_viol + 1;
      end
    end
  end

  task automatic do_reset();
    @(negedge Clock_50);
    Reset = 1'b1;
    Rx_start = 1'b0;
    Tx_start = 1'b0;
    Rx_data_ready = 1'b0;
    Rx_frame_error = 1'b0;
    Rx_data = 8'h00;
    tx_hold = 1'b0;
    repeat (3) @(negedge Clock_50);
    Reset = 1'b0;
  endtask

  // Present one byte, wait for Rx_unload, then idle for gap cycles.
  task automatic feed_byte(input logic [7:0] b, input logic err, input int gap);
    int n = 0;
    Rx_data = b;
    Rx_frame_error = err;
    Rx_data_ready = 1'b1;
    do begin
      @(negedge Clock_50);
      n++;
    end while (Rx_unload !== 1'b1 && n < 200);
    if (Rx_unload !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_unload_timeout: byte %02h got no Rx_unload, required one within 200 cycles", b);
    end
    Rx_data_ready = 1'b0;
    Rx_frame_error = 1'b0;
    if (!(err && ERR_EN_TB)) exp_q.push_back(b);
    repeat (gap) @(negedge Clock_50);
  endtask

  task automatic wait_tx_done(input int limit);
    int n = 0;
    while (Tx_done !== 1'b1 && n < limit) begin
      @(negedge Clock_50);
      n++;
    end
    n_checks++;
    if (Tx_done !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_done: Tx_done=%0b after %0d cycles, required 1", Tx_done, limit);
    end
  endtask

  // Pop the expected queue against the observed Tx_data stream.
  task automatic compare_stream(input string name);
    int bad = -1;
    logic [7:0] e, o;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: %0d Tx_load pulses, required %0d", name, obs_q.size(), exp_q.size());
    end
    n_checks++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (bad < 0 && obs_q[i] !== exp_q[i]) begin
        bad = i;
        o = obs_q[i];
        e = exp_q[i];
      end
    end
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s_data: byte %0d Tx_data=%02h, required %02h", name, bad, o, e);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge Clock_50);
    n_checks++;
    if ({Rx_unload, Tx_load} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_pulses: Rx_unload,Tx_load=%b, required 00", {Rx_unload, Tx_load});
    end
    n_checks++;
    if (Tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_tx_data: %02h, required 00", Tx_data);
    end
    n_checks++;
    if ({Mem_we, Mem_addr, Mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mem_port: we=%0b addr=%0d wdata=%02h, required all 0", Mem_we, Mem_addr, Mem_wdata);
    end
    n_checks++;
    if ({Rx_done, Tx_done, Rx_count, Error_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_status: Rx_done=%0b Tx_done=%0b Rx_count=%0d Error_count=%0d, required all 0",
               Rx_done, Tx_done, Rx_count, Error_count);
    end
  endtask

  task automatic test_basic_receive();
    int bad = -1;
    do_reset();
    exp_q.delete();
    Rx_start = 1'b1;
    for (int i = 0; i < NUM_BYTES; i++) feed_byte(8'(i), 1'b0, int'($urandom_range(20, 100)));
    repeat (2) @(negedge Clock_50);
    n_checks++;
    if (Rx_count !== 10'd512) begin
      n_fail++;
      $display("FAIL rx_count: %0d, required 512", Rx_count);
    end
    n_checks++;
    if (Rx_done !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_done: %0b, required 1", Rx_done);
    end
    n_checks++;
    if (unload_cnt != NUM_BYTES) begin
      n_fail++;
      $display("FAIL rx_unload_count: %0d pulses, required %0d", unload_cnt, NUM_BYTES);
    end
    n_checks++;
    for (int i = 0; i < NUM_BYTES; i++)
      if (bad < 0 && ram[i] !== 8'(i)) bad = i;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL ram_contents: RAM[%0d]=%02h, required %02h", bad, ram[bad], 8'(bad));
    end
  endtask

  task automatic test_tx_after_rx();
    Tx_start = 1'b1;
    wait_tx_done(20000);
    compare_stream("tx_after_rx");
  endtask

  task automatic test_overlap();
    do_reset();
    exp_q.delete();
    Rx_start = 1'b1;
    repeat (25) @(negedge Clock_50);
    Tx_start = 1'b1;
    repeat (10) @(negedge Clock_50);
    n_checks++;
    if (obs_q.size() != 0 || Mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL overlap_stall: %0d loads, Mem_we=%0b before any byte, required 0 and 0", obs_q.size(), Mem_we);
    end
    for (int i = 0; i < NUM_BYTES; i++) feed_byte(8'(i * 37 + 5), 1'b0, int'($urandom_range(2, 8)));
    wait_tx_done(20000);
    n_checks++;
    if (order_viol != 0) begin
      n_fail++;
      $display("FAIL overlap_order: %0d loads ahead of Rx_count, required 0", order_viol);
    end
    compare_stream("overlap");
  endtask

  task automatic test_collision();
    int n = 0;
    do_reset();
    exp_q.delete();
    Rx_start = 1'b1;
    Tx_start = 1'b1;
    feed_byte(8'h11, 1'b0, 2);
    while (obs_q.size() < 1 && n < 100) begin
      @(negedge Clock_50);
      n++;
    end
    tx_hold = 1'b1;
    feed_byte(8'h22, 1'b0, 15);
    // Release the transmitter in the same cycle the next byte arrives.
    Rx_data = 8'h33;
    Rx_data_ready = 1'b1;
    tx_hold = 1'b0;
    @(negedge Clock_50);
    n_checks++;
    if ({Mem_we, Mem_addr, Mem_wdata} !== {1'b1, 9'd2, 8'h33}) begin
      n_fail++;
      $display("FAIL collision_write: we=%0b addr=%0d wdata=%02h, required 1 2 33", Mem_we, Mem_addr, Mem_wdata);
    end
    Rx_data_ready = 1'b0;
    exp_q.push_back(8'h33);
    @(negedge Clock_50);
    n_checks++;
    if ({Mem_we, Mem_addr} !== {1'b0, 9'd1}) begin
      n_fail++;
      $display("FAIL collision_read: we=%0b addr=%0d, required 0 1", Mem_we, Mem_addr);
    end
    n = 0;
    while (obs_q.size() < 3 && n < 100) begin
      @(negedge Clock_50);
      n++;
    end
    compare_stream("collision");
  endtask

  task automatic test_frame_error();
    do_reset();
    exp_q.delete();
    Rx_start = 1'b1;
    for (int i = 0; i < 10; i++) feed_byte(8'(8'hC0 + i), (i == 5), 3);
    repeat (2) @(negedge Clock_50);
    n_checks++;
    if (ram[5] !== (ERR_EN_TB ? 8'hC6 : 8'hC5)) begin
      n_fail++;
      $display("FAIL frame_err_ram5: %02h, required %02h", ram[5], ERR_EN_TB ? 8'hC6 : 8'hC5);
    end
    n_checks++;
    if (ram[4] !== 8'hC4) begin
      n_fail++;
      $display("FAIL frame_err_ram4: %02h, required C4", ram[4]);
    end
    n_checks++;
    if (Rx_count !== (ERR_EN_TB ? 10'd9 : 10'd10)) begin
      n_fail++;
      $display("FAIL frame_err_count: Rx_count=%0d, required %0d", Rx_count, ERR_EN_TB ? 9 : 10);
    end
    n_checks++;
    if (Error_count !== (ERR_EN_TB ? 8'd1 : 8'd0)) begin
      n_fail++;
      $display("FAIL error_count: %0d, required %0d", Error_count, ERR_EN_TB ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    Rx_start = 1'b1;
    for (int i = 0; i < 100; i++) feed_byte(8'(i + 64), 1'b0, 2);
    Rx_data = 8'hEE;
    Rx_data_ready = 1'b1;
    @(negedge Clock_50);
    n_checks++;
    if (Mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_write: Mem_we=%0b for byte 100, required 1", Mem_we);
    end
    Reset = 1'b1;
    Rx_start = 1'b0;
    Rx_data_ready = 1'b0;
    #1;
    n_checks++;
    if (Mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_partial: Mem_we=%0b with Reset high, required 0", Mem_we);
    end
    @(negedge Clock_50);
    n_checks++;
    if ({Rx_unload, Tx_load, Tx_data, Mem_addr, Mem_wdata, Mem_we, Rx_done, Tx_done, Rx_count, Error_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: Rx_count=%0d Mem_we=%0b Mem_addr=%0d Rx_unload=%0b, required all outputs 0",
               Rx_count, Mem_we, Mem_addr, Rx_unload);
    end
    Reset = 1'b0;
    Rx_start = 1'b1;
    feed_byte(8'h99, 1'b0, 2);
    n_checks++;
    if (ram[0] !== 8'h99 || Rx_count !== 10'd1) begin
      n_fail++;
      $display("FAIL reset_restart: RAM[0]=%02h Rx_count=%0d, required 99 and 1", ram[0], Rx_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_receive();
    test_tx_after_rx();
    test_overlap();
    test_collision();
    test_frame_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_xfer_ctrl.md
# uart_xfer_ctrl

Sequencing controller for the UART loopback datapath. It drains bytes from the UART receive controller into a 512-byte dual-port RAM, then streams them back out through the UART transmit controller. RAM port A is shared between the receive writer and the transmit reader through a fixed-priority arbiter, so transmission may overlap reception. It sits between the UART receive/transmit controllers and the DP-RAM in the top level. Completion is signalled on Rx_done/Tx_done.

## Interface
- NUM_BYTES, 512, number of bytes per transfer
- ADDR_W, 9, RAM address width; NUM_BYTES ≤ 2^ADDR_W
- Clock_50  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- Rx_start  in  1  level; starts reception when high in RX_IDLE
- Tx_start  in  1  level; starts transmission when high in TX_IDLE
- Rx_data_ready  in  1  receive controller holds a byte
- Rx_data  in  8  received byte
- Rx_frame_error  in  1  frame error flag for the current Rx_data
- Rx_unload  out  1  one-cycle pulse; receive controller releases its byte
- Tx_empty  in  1  transmit controller can accept a byte
- Tx_load  out  1  one-cycle pulse; transmit controller accepts Tx_data
- Tx_data  out  8  byte to transmit, registered
- Mem_addr  out  ADDR_W  RAM port A address
- Mem_wdata  out  8  RAM port A write data
- Mem_we  out  1  RAM port A write enable
- Mem_rdata  in  8  RAM port A read data, valid one cycle after the address
- Rx_done  out  1  sticky; NUM_BYTES written
- Tx_done  out  1  sticky; NUM_BYTES loaded and the last byte drained
- Rx_count  out  ADDR_W+1  bytes written so far
- Error_count  out  8  saturating frame-error counter

## Operation
- **Reset values.** All outputs are 0 and both FSMs are in IDLE. rx_ptr and tx_ptr are 0. RAM contents are not touched.
- **Reset mid-operation.** Either FSM aborts to IDLE within one cycle, with no partial Mem_we or Tx_load.
- **RX FSM:**
  - RX_IDLE: Rx_start → RX_WAIT.
  - RX_WAIT: Rx_data_ready → latch Rx_data, pulse Rx_unload next cycle, → RX_WRITE.
  - RX_WRITE: requests the port. When granted: Mem_we=1, Mem_addr=rx_ptr, rx_ptr++. Then → RX_DONE if rx_ptr becomes NUM_BYTES, else → RX_WAIT.
  - RX_DONE: terminal until Reset.
- **TX FSM:**
  - TX_IDLE: Tx_start → TX_REQ.
  - TX_REQ: a read is eligible when tx_ptr < rx_ptr or Rx_done. When eligible and granted, drive Mem_addr=tx_ptr with Mem_we=0, → TX_RD.
  - TX_RD: latch Mem_rdata into Tx_data, → TX_LOAD.
  - TX_LOAD: wait for Tx_empty=1, then pulse Tx_load, tx_ptr++, → TX_BUSY.
  - TX_BUSY: skip one cycle, then wait for Tx_empty=1. Then → TX_DONE if tx_ptr = NUM_BYTES, else → TX_REQ.
  - TX_DONE: terminal until Reset.
- **Arbiter.** RX write has priority. A denied TX read stays in TX_REQ and retries every cycle. The port is idle with Mem_we=0 when there is no request.
- **Overlap.** Same-cycle write and read of one address cannot occur: eligibility uses rx_ptr registered before the write.
- **Pointers** are ADDR_W+1 bits wide and do not wrap. Rx_count = rx_ptr.

## Timing
- Rx_data_ready seen at cycle n → Rx_unload at n+1 → Mem_we at n+1 at the earliest, if the port is free.
- TX read: address at cycle t, Tx_data valid at t+2, Tx_load at t+2 at the earliest.
- Mem_addr, Mem_we and Mem_wdata are combinational from state and grant. Tx_load, Rx_unload and Tx_data are registered.
- Rx_done rises the cycle after the last write. Tx_done rises the cycle after the final Tx_empty=1 in TX_BUSY.

## Configuration
- UART_XFER_ERR_COUNT_EN **defined:**
  - A byte with Rx_frame_error=1 is unloaded but not written, and rx_ptr is unchanged.
  - Error_count increments and saturates at 255.
- **Undefined:** all bytes are written regardless of Rx_frame_error, and Error_count is tied to 0.

## Structure
- Package uart_xfer_pkg holds:
  - the rx_state_type and tx_state_type enums;
  - the NUM_BYTES_DEFAULT constant;
  - the ERR_CNT_MAX constant.
- One sub-module, uart_xfer_port_arb, contains the grant logic and the port A mux. Both FSMs stay in uart_xfer_ctrl.

## Test plan
- **Basic receive:** Reset, Rx_start=1, then feed 512 bytes 0x00..0xFF twice with gaps of 20–100 cycles. Expect RAM[0..511] to match, Rx_count=512, Rx_done=1, and exactly 512 Rx_unload pulses.
- **Transmit after receive:** Tx_start after Rx_done, with a transmit model that holds Tx_empty low for 10 cycles per byte. Expect 512 Tx_load pulses with Tx_data in address order, then Tx_done.
- **Overlapped start:** Tx_start at reset+25 with Rx_start asserted. TX must stall in TX_REQ while tx_ptr = rx_ptr, and the output must equal the input.
- **Collision:** force an RX write and TX read request in the same cycle. Expect the write granted and the read issued the next cycle with its value correct.
- **Frame error (UART_XFER_ERR_COUNT_EN):** assert Rx_frame_error on byte 5. Expect byte 6 stored at address 5 and Error_count=1. With the macro off, expect byte 5 stored and Error_count=0.
- **Reset mid-transfer:** Reset at byte 100. Expect all outputs 0 next cycle. A restart must rewrite from address 0.
